div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative unsigned divider producing both quotient and remainder.
- Runtime divisor; parametrised dividend and divisor widths.
- Generalises the fixed divide-by-3 used for glyph-cell addressing to any small divisor: glyph widths, scale factors, tile-count arithmetic.
- Sits between the timing generator and glyph/tile address logic; valid/ready handshake on input and output.

Parameters:
- WIDTH, 7, dividend and quotient width in bits (>=2).
- DWIDTH, 3, divisor and remainder width in bits (>=1, <=WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend/divisor presented
- in_ready  output  1  divider can accept an operation
- dividend  input  WIDTH  unsigned dividend
- divisor  input  DWIDTH  unsigned divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  dividend / divisor
- remainder  output  DWIDTH  dividend % divisor
- div_zero  output  1  divisor was zero for this result

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - in_ready=1 after release; out_valid=0.
  - quotient, remainder, div_zero = 0.
  - Internal shift/partial registers = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready: latch dividend and divisor, clear partial remainder (DWIDTH+1 bits), load bit counter.
  - Divisor != 0 -> BUSY. Divisor == 0 -> DONE directly.
- BUSY:
  - in_ready=0.
  - One restoring step per cycle, MSB first:
    - partial = {partial[DWIDTH-1:0], next dividend bit}.
    - If partial >= divisor: subtract divisor, quotient bit = 1; else quotient bit = 0.
  - Counter decrements; after the last bit -> DONE.
  - Base latency: accept edge + WIDTH BUSY cycles; out_valid rises at the edge ending the WIDTH-th step.
- DONE:
  - out_valid=1; quotient, remainder, div_zero stable.
  - Held stable indefinitely while out_ready=0 (backpressure).
  - On out_valid && out_ready: -> IDLE, out_valid=0 next cycle.
  - in_ready stays 0 in DONE. No same-cycle accept; minimum initiation interval is WIDTH+2 cycles.
- Divide by zero: quotient = all ones, remainder = 0, div_zero=1, reaches DONE one cycle after accept.
- Width rules:
  - Remainder always fits in DWIDTH bits.
  - Partial register has one guard bit to make the compare safe.
  - No truncation of quotient.
- Inputs are sampled only at the accept edge; changes afterwards are ignored.
- Reset asserted mid-BUSY or mid-DONE aborts immediately. The result is lost; no out_valid pulse.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: DIV_SEQ_EARLY_EXIT_EN
- Defined:
  - At accept, a leading-zero count of the dividend sets the starting bit index to the highest set bit.
  - The BUSY step count equals the number of significant dividend bits. Dividend=0 takes 1 step.
  - Skipped upper quotient bits are 0.
  - Results are identical to the non-early-exit build; only latency differs.
- Undefined: BUSY always lasts exactly WIDTH cycles regardless of operand.

Test Plan:
- WIDTH=7, DWIDTH=3; dividend=85, divisor=3, out_ready=1 -> quotient=28, remainder=1, div_zero=0. out_valid rises 7 cycles after the accept edge (3 cycles with EARLY_EXIT_EN only if dividend<8; here 7).
- dividend=127, divisor=7 -> quotient=18, remainder=1. dividend=5, divisor=6 -> quotient=0, remainder=5.
- dividend=100, divisor=0 -> quotient=127, remainder=0, div_zero=1, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout, in_valid pulses ignored. Release -> one transfer, then in_ready=1.
- rst_n pulsed low for 1 cycle mid-BUSY -> out_valid=0, in_ready=1 after release. Next op 42/5 -> quotient=8, remainder=2.
- Exhaustive sweep, all dividends 0..127 by divisors 0..7 with random out_ready -> every result matches / and %. Cycle counts match the build mode (WIDTH fixed, or significant-bit count under DIV_SEQ_EARLY_EXIT_EN).

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative restoring unsigned divider with valid/ready handshakes.
// Produces quotient and remainder of a WIDTH-bit dividend by a DWIDTH-bit
// runtime divisor, one quotient bit per cycle, MSB first.
// Optional build macro DIV_SEQ_EARLY_EXIT_EN: skip the dividend's leading
// zeros so BUSY lasts only as many cycles as the dividend has significant
// bits (minimum one). Results are identical in both builds.
module div_seq #(
  parameter int WIDTH  = 7,
  parameter int DWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [DWIDTH-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  quotient,
  output logic [DWIDTH-1:0] remainder,
  output logic              div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // shreg starts as the dividend and fills with quotient bits from the LSB;
  // once the last step has run it holds the complete quotient.
  logic [WIDTH-1:0]  shreg;
  // One guard bit above the remainder width keeps the compare exact.
  logic [DWIDTH:0]   part;
  logic [DWIDTH-1:0] dsr;
  logic [CW-1:0]     cnt;
  logic              dz;

  logic              accept;
  logic              last_step;
  logic [DWIDTH+1:0] step_res;
  logic [CW-1:0]     start_cnt;
  logic [WIDTH-1:0]  start_val;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // Returns {new partial remainder, quotient bit}.
  function automatic logic [DWIDTH+1:0] restore_step(
    input logic [DWIDTH:0]   p,
    input logic              b,
    input logic [DWIDTH-1:0] d
  );
    logic [DWIDTH:0] t;
    t = {p[DWIDTH-1:0], b};
    if (t >= {1'b0, d}) begin
      return {t - {1'b0, d}, 1'b1};
    end
    return {t, 1'b0};
  endfunction

`ifdef DIV_SEQ_EARLY_EXIT_EN
  // Number of significant bits in v; a zero value still needs one step.
  function automatic logic [CW-1:0] sig_bits(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = CW'(1);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        n = CW'(i + 1);
      end
    end
    return n;
  endfunction
`endif

  // Step count and pre-aligned dividend loaded at accept.
  always_comb begin
`ifdef DIV_SEQ_EARLY_EXIT_EN
    start_cnt = sig_bits(dividend);
    start_val = dividend << (CW'(WIDTH) - start_cnt);
`else
    start_cnt = CW'(WIDTH);
    start_val = dividend;
`endif
  end

  assign step_res  = restore_step(part, shreg[WIDTH-1], dsr);
  assign last_step = (cnt == CW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture at accept, then one restoring step per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      part  <= '0;
      dsr   <= '0;
      cnt   <= '0;
      dz    <= 1'b0;
    end else if (accept) begin
      dsr  <= divisor;
      part <= '0;
      if (divisor == '0) begin
        // Divide by zero: all-ones quotient, zero remainder, no iteration.
        shreg <= '1;
        cnt   <= '0;
        dz    <= 1'b1;
      end else begin
        shreg <= start_val;
        cnt   <= start_cnt;
        dz    <= 1'b0;
      end
    end else if (state == BUSY) begin
      part  <= step_res[DWIDTH+1:1];
      shreg <= {shreg[WIDTH-2:0], step_res[0]};
      cnt   <= cnt - CW'(1);
    end
  end

  assign quotient  = shreg;
  assign remainder = part[DWIDTH-1:0];
  assign div_zero  = dz;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and sweep bench for div_seq with a reference model
// checked on every cycle plus literal expectations for selected operations.
module tb_div_seq;

  localparam int WIDTH  = 7;
  localparam int DWIDTH = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  dividend = '0;
  logic [DWIDTH-1:0] divisor = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  quotient;
  logic [DWIDTH-1:0] remainder;
  logic              div_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  div_seq #(.WIDTH(WIDTH), .DWIDTH(DWIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edges from the accept edge until out_valid is visible.
  function automatic int exp_lat(input int a, input int b);
    if (b == 0) return 0;
`ifdef DIV_SEQ_EARLY_EXIT_EN
    for (int k = WIDTH; k >= 1; k--) begin
      if (a >= (1 << (k - 1))) return k;
    end
    return 1;
`else
    return WIDTH;
`endif
  endfunction

  // Reference model: one operation in flight, result due at a known cycle.
  bit m_busy = 0;
  bit m_due_now;
  int m_q, m_r, m_dz, m_due;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_div_zero", int'(div_zero), 0);
    end else begin
      m_due_now = m_busy && (cyc >= m_due);
      check("in_ready", int'(in_ready), int'(!m_busy));
      check("out_valid", int'(out_valid), int'(m_due_now));
      if (m_due_now) begin
        check("quotient", int'(quotient), m_q);
        check("remainder", int'(remainder), m_r);
        check("div_zero", int'(div_zero), m_dz);
        if (out_ready) m_busy = 0;
      end else if (!m_busy && in_valid) begin
        m_busy = 1;
        if (divisor == 0) begin
          m_q = (1 << WIDTH) - 1; m_r = 0; m_dz = 1;
        end else begin
          m_q = int'(dividend) / int'(divisor);
          m_r = int'(dividend) % int'(divisor);
          m_dz = 0;
        end
        m_due = cyc + 1 + exp_lat(int'(dividend), int'(divisor));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int a, input int b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    dividend = WIDTH'(a);
    divisor  = DWIDTH'(b);
    tick();
    in_valid = 1'b0;
    dividend = ~dividend;
    divisor  = ~divisor;
  endtask

  task automatic wait_valid(output int q, output int r, output int dz, output int lat);
    int n;
    n = 0;
    q = -1; r = -1; dz = -1; lat = -1;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
    end else begin
      lat = n; q = int'(quotient); r = int'(remainder); dz = int'(div_zero);
    end
  endtask

  // rdy_mode 1: out_ready held high; 0: random out_ready each cycle.
  task automatic drain(input int rdy_mode);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < 100) begin
      out_ready = (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) done = 1;
      tick();
      n++;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic run_op(input int a, input int b, input int rdy_mode,
                        output int q, output int r, output int dz, output int lat);
    issue(a, b);
    wait_valid(q, r, dz, lat);
    drain(rdy_mode);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, dz, lat;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("in_ready_after_reset", int'(in_ready), 1);
    check("out_valid_after_reset", int'(out_valid), 0);

    out_ready = 1'b1;
    run_op(85, 3, 1, q, r, dz, lat);
    check("85/3_q", q, 28); check("85/3_r", r, 1);
    check("85/3_dz", dz, 0); check("85/3_lat", lat, 7);

    run_op(127, 7, 1, q, r, dz, lat);
    check("127/7_q", q, 18); check("127/7_r", r, 1); check("127/7_lat", lat, 7);

    run_op(5, 6, 1, q, r, dz, lat);
    check("5/6_q", q, 0); check("5/6_r", r, 5);
`ifdef DIV_SEQ_EARLY_EXIT_EN
    check("5/6_lat", lat, 3);
`else
    check("5/6_lat", lat, 7);
`endif

    run_op(100, 0, 1, q, r, dz, lat);
    check("100/0_q", q, 127); check("100/0_r", r, 0);
    check("100/0_dz", dz, 1); check("100/0_lat", lat, 0);

    // Backpressure: result held for 10 cycles, input pulses ignored.
    out_ready = 1'b0;
    issue(99, 4);
    wait_valid(q, r, dz, lat);
    check("99/4_q", q, 24); check("99/4_r", r, 3);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = WIDTH'(i * 11);
      divisor  = DWIDTH'(i);
      tick();
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_quotient", int'(quotient), 24);
      check("bp_remainder", int'(remainder), 3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);

    // Reset pulse mid-BUSY aborts the operation.
    issue(120, 7);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    tick();
    check("abort_no_pulse", int'(out_valid), 0);
    out_ready = 1'b1;
    run_op(42, 5, 1, q, r, dz, lat);
    check("42/5_q", q, 8); check("42/5_r", r, 2);
`ifdef DIV_SEQ_EARLY_EXIT_EN
    check("42/5_lat", lat, 6);
`else
    check("42/5_lat", lat, 7);
`endif

    // Sweep of every operand pair with random output backpressure.
    for (int a = 0; a < (1 << WIDTH); a++) begin
      for (int b = 0; b < (1 << DWIDTH); b++) begin
        run_op(a, b, 0, q, r, dz, lat);
        check("sweep_lat", lat, exp_lat(a, b));
      end
    end

    out_ready = 1'b0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
